// File: rtl/m_div_controller.sv
//==============================================================================
// m_div_controller - restoring-divider sequencer and sign-correcting result stage
// Optional macro M_DIV_FASTPATH_EN: finish x/0 and INT_MIN/-1 directly from IDLE.
// Revision: 1.0
//==============================================================================
`default_nettype none

`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH    2
`define MUX_R_KEEP      2'd0
`define MUX_R_A         2'd1
`define MUX_R_A_NEG     2'd2
`define MUX_R_SUB_KEEP  2'd3
`define MUX_D_LENGTH    2
`define MUX_D_KEEP      2'd0
`define MUX_D_B         2'd1
`define MUX_D_B_NEG     2'd2
`define MUX_D_SHR       2'd3
`define MUX_Z_LENGTH    2
`define MUX_Z_KEEP      2'd0
`define MUX_Z_ZERO      2'd1
`define MUX_Z_SHL_ADD   2'd2
`endif

module m_div_controller (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [31:0]              rs1,
  input  logic [31:0]              rs2,
  input  logic [31:0]              R,
  input  logic [31:0]              Z,
  output logic [`MUX_R_LENGTH-1:0] mux_R,
  output logic [`MUX_D_LENGTH-1:0] mux_D,
  output logic [`MUX_Z_LENGTH-1:0] mux_Z,
  output logic                     busy,
  output logic                     valid,
  output logic [31:0]              result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic        sgn;

  assign sgn = ~op[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    mux_R     = `MUX_R_KEEP;
    mux_D     = `MUX_D_KEEP;
    mux_Z     = `MUX_Z_KEEP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef M_DIV_FASTPATH_EN
          if (rs2 == 32'd0) begin
            valid_d  = 1'b1;
            result_d = op[1] ? rs1 : 32'hFFFF_FFFF;
          end else if (sgn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)) begin
            valid_d  = 1'b1;
            result_d = op[1] ? 32'd0 : 32'h8000_0000;
          end else
`endif
          begin
            // Datapath loads magnitudes; signs are restored in FIX.
            mux_R     = (sgn && rs1[31]) ? `MUX_R_A_NEG : `MUX_R_A;
            mux_D     = (sgn && rs2[31]) ? `MUX_D_B_NEG : `MUX_D_B;
            mux_Z     = `MUX_Z_ZERO;
            is_rem_d  = op[1];
            neg_quo_d = sgn && (rs1[31] ^ rs2[31]) && (rs2 != 32'd0);
            neg_rem_d = sgn && rs1[31];
            cnt_d     = 5'd0;
            state_d   = S_ITER;
          end
        end
      end

      S_ITER: begin
        mux_R = `MUX_R_SUB_KEEP;
        mux_D = `MUX_D_SHR;
        mux_Z = `MUX_Z_SHL_ADD;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_rem_q) begin
          result_d = neg_rem_q ? (32'd0 - R) : R;
        end else begin
          result_d = neg_quo_q ? (32'd0 - Z) : Z;
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign valid  = valid_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: doc/m_div_controller.md
# m_div_controller

Sequencing and result stage for the M-unit restoring divider. Accepts a DIV/DIVU/REM/REMU request, drives the remainder/divisor/quotient mux selects of the divider register datapath for a load cycle plus 32 iterations, and sign-corrects the raw remainder and quotient into a 32-bit result. It presents a start/busy/valid handshake to the M-unit top level.

## Interface
Parameters:
- none. Mux encodings and widths are the `MUX_*` macros from `m_definitions.svh`.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request strobe, sampled only in IDLE
- `op`  in  2  operation code:
  - 00 DIV
  - 01 DIVU
  - 10 REM
  - 11 REMU
- `rs1`, `rs2`  in  32  dividend and divisor; must be held stable in the `start` cycle only
- `R`  in  32  remainder register from the datapath
- `Z`  in  32  quotient register from the datapath
- `mux_R`  out  `MUX_R_LENGTH`  remainder select
- `mux_D`  out  `MUX_D_LENGTH`  divisor select
- `mux_Z`  out  `MUX_Z_LENGTH`  quotient select
- `busy`  out  1  high when state ≠ IDLE
- `valid`  out  1  one-cycle completion pulse, registered
- `result`  out  32  final value, registered; held until the next completion

## Operation
- **States:** IDLE, ITER, FIX.
- **IDLE, `start`=1:**
  - Signed flag `sgn` = ~op[0].
  - Selects are driven combinationally in this cycle:
    - `mux_R` = A_NEG if `sgn` & rs1[31], else A.
    - `mux_D` = B_NEG if `sgn` & rs2[31], else B.
    - `mux_Z` = ZERO.
  - Latch the following, then go to ITER with the 5-bit counter = 0:
    - `is_rem` = op[1].
    - `neg_q` = `sgn` & (rs1[31]^rs2[31]) & (rs2≠0).
    - `neg_r` = `sgn` & rs1[31].
- **ITER:**
  - `mux_R` = SUB_KEEP, `mux_D` = SHR, `mux_Z` = SHL_ADD.
  - The counter increments every cycle. At counter = 31, go to FIX.
- **FIX:**
  - Selects are KEEP.
  - `result` <= `is_rem` ? (`neg_r` ? −R : R) : (`neg_q` ? −Z : Z).
  - `valid` <= 1; go to IDLE.
- **Default selects:** KEEP in all other cycles, including IDLE without `start`.
- **Arithmetic:** all negation is 32-bit two's complement, wrapping.
  - 0x80000000 used as a magnitude is 2^31.
  - DIV 0x80000000 / −1 therefore yields quotient 0x80000000 and remainder 0 with no special handling.
- **Divide by zero:** the iteration yields Z = 0xFFFFFFFF and R = |rs1|. Because `neg_q` is cleared, the quotient is 0xFFFFFFFF and the remainder equals rs1 (RISC-V semantics).
- **`start` while busy:** ignored; there is no queueing.
- **`start` in the cycle `valid` is high:** accepted, since the state is IDLE.
- **`op` and `rs*`:** ignored except in the `start` cycle.

## Timing
- **Normal latency:** `start` sampled at edge 0; ITER covers cycles 1–32; FIX is cycle 33; `valid` is high in cycle 34.
- **`busy`:** high in cycles 1–33.
- **Fast path:** when compiled in, `valid` is high in cycle 1.
- **Reset (asynchronous, anytime, including mid-operation):**
  - state = IDLE, counter = 0, `valid` = 0, `result` = 0, latched flags = 0.
  - Selects are KEEP, `busy` = 0.
  - Any in-flight operation is discarded; no `valid` is produced for it.

## Configuration
- **Macro:** `M_DIV_FASTPATH_EN`.
- **Defined:** in IDLE with `start`, two special cases complete without iterating:
  - rs2 = 0: result = 0xFFFFFFFF for DIV/DIVU, rs1 for REM/REMU.
  - `sgn` & rs1 = 0x80000000 & rs2 = 0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM.
  - In both cases `result` and `valid` are registered at that edge, state stays IDLE, and the datapath selects stay KEEP.
- **Undefined:** all operations take the full 34-cycle path. Results are identical via the arithmetic rules above.

## Test plan
- DIVU 100/7 → `result` = 14, `valid` in cycle 34. REMU 100/7 → 2.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Check latency 1 cycle with `M_DIV_FASTPATH_EN`, 34 cycles without.
- DIVU 5/0 → 0xFFFFFFFF. REM −5/0 → 0xFFFFFFFB. DIV −5/0 → 0xFFFFFFFF.
- Second `start` (DIVU 9/3) pulsed in cycle 10 of a DIVU 100/7 → ignored, single `valid` with 14. Back-to-back `start` in the `valid` cycle → accepted, 3 returned 34 cycles later.
- Assert `resetn` low in cycle 15 of an operation → `busy`/`valid`/`result` = 0 immediately, selects KEEP, no `valid` after release. A subsequent DIVU 8/2 → 4.
